// File: rtl/irom_resp.sv
// Instruction ROM responder: one fetch in flight against a synchronous memory macro.
// inst_sram_ok rises LATENCY cycles after accept; no queue, so the IF stage holds its PC until ok or cancel.
module irom_resp #(
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'hbfc0_0000,
    parameter int          AW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_ren,
    input  logic [31:0]   irom_pc_i,
    input  logic          cancel,
    output logic [31:0]   irom_inst_o,
    output logic          inst_sram_ok,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 2);

    state_t      state_q, state_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] data_hold_q, data_hold_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rst_blk_q, rst_blk_d;
    logic        addr_match;
    logic        accept;

    always_comb begin
        addr_match  = (irom_pc_i == hold_addr_q);
        // rst_blk_q keeps the memory quiet for the first cycle out of reset
        accept      = !reset && !rst_blk_q && !cancel && inst_ren &&
                      ((state_q == IDLE) || ((state_q == DONE) && !addr_match));
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        data_hold_d = data_hold_q;
        cnt_d       = cnt_q;
        rst_blk_d   = reset;

        if (cancel) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d     = WAIT;
            hold_addr_d = irom_pc_i;
            cnt_d       = CNT_INIT;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT: begin
                    // cnt only counts down, so its reload value marks the first WAIT cycle
                    if (cnt_q == CNT_INIT) begin
                        data_hold_d = mem_rdata;
                    end
                    if (cnt_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    if (!inst_ren) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rst_blk_q <= rst_blk_d;
        if (reset) begin
            state_q     <= IDLE;
            hold_addr_q <= 32'd0;
            data_hold_q <= 32'd0;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            data_hold_q <= data_hold_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_en       = accept;
    assign mem_addr     = AW'((irom_pc_i - BASE_ADDR) >> 2);
    assign inst_sram_ok = !reset && (state_q == DONE) && addr_match && !cancel;
    assign irom_inst_o  = inst_sram_ok ? data_hold_q : 32'd0;

endmodule

// File: tb/tb_irom_resp.sv
// Directed bench: three responders (LATENCY 2, 4, 5) share one stimulus, each with its own memory model.
module tb_irom_resp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, inst_ren, cancel;
    logic [31:0] pc;

    logic        en2, en4, en5, ok2, ok4, ok5;
    logic [11:0] a2, a4, a5;
    logic [31:0] rd2, rd4, rd5, i2, i4, i5;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memw(input logic [11:0] a);
        return (a == 12'd0) ? 32'h3c08_0001 : (32'h2400_0000 | {20'd0, a});
    endfunction

    always @(posedge clk) begin
        if (en2) rd2 <= memw(a2);
        if (en4) rd4 <= memw(a4);
        if (en5) rd5 <= memw(a5);
    end

    irom_resp #(.LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .inst_ren(inst_ren), .irom_pc_i(pc), .cancel(cancel),
        .irom_inst_o(i2), .inst_sram_ok(ok2), .mem_en(en2), .mem_addr(a2), .mem_rdata(rd2));
    irom_resp #(.LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .inst_ren(inst_ren), .irom_pc_i(pc), .cancel(cancel),
        .irom_inst_o(i4), .inst_sram_ok(ok4), .mem_en(en4), .mem_addr(a4), .mem_rdata(rd4));
    irom_resp #(.LATENCY(5)) u5 (
        .clk(clk), .reset(reset), .inst_ren(inst_ren), .irom_pc_i(pc), .cancel(cancel),
        .irom_inst_o(i5), .inst_sram_ok(ok5), .mem_en(en5), .mem_addr(a5), .mem_rdata(rd5));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; inst_ren = 1'b1; cancel = 1'b0; pc = 32'hbfc0_0000;
        tick; tick; #1;
        checks++;
        if ({en2, en4, en5, ok2, ok4, ok5} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000", {en2, en4, en5, ok2, ok4, ok5});
        end
        checks++;
        if ((i2 | i4 | i5) !== 32'd0) begin
            errors++; $display("FAIL reset_inst: got %h %h %h expected 0", i2, i4, i5);
        end
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if ({en2, en4, en5, ok2, ok4, ok5} !== 6'b0 || (i2 | i4 | i5) !== 32'd0) begin
            errors++; $display("FAIL post_reset: got ctrl %b inst %h expected 0", {en2, en4, en5, ok2, ok4, ok5}, i2);
        end
        inst_ren = 1'b0;
        tick;
    endtask

    task automatic test_latency;
        inst_ren = 1'b1; pc = 32'hbfc0_0000;
        #1;
        checks++;
        if ({en2, en4, en5} !== 3'b111 || a2 !== 12'd0) begin
            errors++; $display("FAIL accept_word0: got en %b addr %h expected 111 000", {en2, en4, en5}, a2);
        end
        for (int k = 0; k < 7; k++) begin
            if (k != 0) tick;
            #1;
            checks++;
            if (ok2 !== (k >= 2) || i2 !== ((k >= 2) ? 32'h3c08_0001 : 32'd0)) begin
                errors++; $display("FAIL lat2 k=%0d: got ok %b inst %h", k, ok2, i2);
            end
            checks++;
            if (ok4 !== (k >= 4) || i4 !== ((k >= 4) ? 32'h3c08_0001 : 32'd0)) begin
                errors++; $display("FAIL lat4 k=%0d: got ok %b inst %h", k, ok4, i4);
            end
            checks++;
            if (ok5 !== (k >= 5)) begin
                errors++; $display("FAIL lat5 k=%0d: got ok %b expected %b", k, ok5, (k >= 5));
            end
        end
    endtask

    task automatic test_pc_advance_ren_drop;
        tick;
        pc = 32'hbfc0_0004;
        #1;
        checks++;
        if (ok2 !== 1'b0 || i2 !== 32'd0 || a2 !== 12'd1 || {en2, en4, en5} !== 3'b111) begin
            errors++; $display("FAIL pc_advance: got ok %b inst %h addr %h en %b", ok2, i2, a2, {en2, en4, en5});
        end
        for (int j = 1; j < 7; j++) begin
            tick;
            inst_ren = 1'b0;
            #1;
            checks++;
            if (ok2 !== (j == 2) || i2 !== ((j == 2) ? 32'h2400_0001 : 32'd0)) begin
                errors++; $display("FAIL word1_l2 j=%0d: got ok %b inst %h", j, ok2, i2);
            end
            checks++;
            if (ok4 !== (j == 4) || i4 !== ((j == 4) ? 32'h2400_0001 : 32'd0)) begin
                errors++; $display("FAIL ren_drop_l4 j=%0d: got ok %b inst %h", j, ok4, i4);
            end
            checks++;
            if (ok5 !== (j == 5) || {en2, en4, en5} !== 3'b000) begin
                errors++; $display("FAIL ren_drop_l5 j=%0d: got ok %b en %b", j, ok5, {en2, en4, en5});
            end
        end
    endtask

    task automatic test_cancel;
        tick;
        inst_ren = 1'b1; cancel = 1'b1; pc = 32'hbfc0_0100;
        #1;
        checks++;
        if ({en2, en4, en5, ok2, ok4, ok5} !== 6'b0) begin
            errors++; $display("FAIL accept_vs_cancel: got %b expected 000000", {en2, en4, en5, ok2, ok4, ok5});
        end
        tick;
        cancel = 1'b0;
        #1;
        checks++;
        if (en4 !== 1'b1 || a4 !== 12'h040) begin
            errors++; $display("FAIL cancel_prefetch: got en %b addr %h expected 1 040", en4, a4);
        end
        tick;
        cancel = 1'b1;
        #1;
        checks++;
        if (en4 !== 1'b0 || ok4 !== 1'b0 || i4 !== 32'd0) begin
            errors++; $display("FAIL cancel_cycle: got en %b ok %b inst %h", en4, ok4, i4);
        end
        tick;
        cancel = 1'b0; pc = 32'hbfc0_0380;
        #1;
        checks++;
        if (en4 !== 1'b1 || a4 !== 12'd224 || ok4 !== 1'b0) begin
            errors++; $display("FAIL cancel_idle: got en %b addr %h ok %b expected 1 0e0 0", en4, a4, ok4);
        end
        for (int t = 3; t < 7; t++) begin
            tick; #1;
            checks++;
            if (ok4 !== (t == 6) || i4 !== ((t == 6) ? 32'h2400_00e0 : 32'd0)) begin
                errors++; $display("FAIL word224 t=%0d: got ok %b inst %h", t, ok4, i4);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        tick; tick;
        pc = 32'hbfc0_0000;
        #1;
        checks++;
        if ({en2, en4, en5} !== 3'b111) begin
            errors++; $display("FAIL new_addr_accept: got en %b expected 111", {en2, en4, en5});
        end
        tick;
        reset = 1'b1;
        #1;
        checks++;
        if ({en2, en4, en5, ok2, ok4, ok5} !== 6'b0 || (i2 | i4 | i5) !== 32'd0 || a2 !== 12'd0) begin
            errors++; $display("FAIL reset_in_wait: got ctrl %b inst %h addr %h", {en2, en4, en5, ok2, ok4, ok5}, i2, a2);
        end
        tick;
        reset = 1'b0; pc = 32'hbfc0_0002;
        #1;
        checks++;
        if ({en2, en4, en5, ok2, ok4, ok5} !== 6'b0 || a2 !== 12'd0) begin
            errors++; $display("FAIL after_reset_wait: got ctrl %b addr %h", {en2, en4, en5, ok2, ok4, ok5}, a2);
        end
        tick; #1;
        checks++;
        if (en2 !== 1'b1 || a2 !== 12'd0 || ok2 !== 1'b0) begin
            errors++; $display("FAIL misaligned_accept: got en %b addr %h ok %b", en2, a2, ok2);
        end
        tick; #1;
        checks++;
        if (ok2 !== 1'b0) begin
            errors++; $display("FAIL misaligned_wait: got ok %b expected 0", ok2);
        end
        tick; #1;
        checks++;
        if (ok2 !== 1'b1 || i2 !== 32'h3c08_0001) begin
            errors++; $display("FAIL misaligned_word0: got ok %b inst %h expected 1 3c080001", ok2, i2);
        end
    endtask

    task automatic test_addr_map;
        tick;
        inst_ren = 1'b0; pc = 32'hbfc0_4008;
        #1;
        checks++;
        if (a2 !== 12'h002 || en2 !== 1'b0) begin
            errors++; $display("FAIL addr_wrap_high: got addr %h en %b expected 002 0", a2, en2);
        end
        pc = 32'hbfbf_fffc;
        #1;
        checks++;
        if (a2 !== 12'hfff) begin
            errors++; $display("FAIL addr_wrap_low: got addr %h expected fff", a2);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_pc_advance_ren_drop;
        test_cancel;
        test_reset_mid_wait;
        test_addr_map;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
